// File: rtl/ahb_cache_fill_arbiter.sv
// ahb_cache_fill_arbiter: shares one AHB-Lite port among cache line-fill masters, one buffered address phase per port.
// Define AHB_CACHE_FILL_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
module ahb_cache_fill_arbiter #(
   parameter int N_PORTS = 2,
   parameter int W_ADDR  = 32,
   parameter int W_DATA  = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   output logic [N_PORTS-1:0]        src_hready_resp,
   input  logic [N_PORTS-1:0]        src_hready,
   output logic [N_PORTS-1:0]        src_hresp,
   input  logic [N_PORTS*W_ADDR-1:0] src_haddr,
   input  logic [N_PORTS-1:0]        src_hwrite,
   input  logic [2*N_PORTS-1:0]      src_htrans,
   input  logic [3*N_PORTS-1:0]      src_hsize,
   input  logic [3*N_PORTS-1:0]      src_hburst,
   input  logic [4*N_PORTS-1:0]      src_hprot,
   input  logic [N_PORTS-1:0]        src_hmastlock,
   input  logic [N_PORTS*W_DATA-1:0] src_hwdata,
   output logic [N_PORTS*W_DATA-1:0] src_hrdata,
   input  logic                      dst_hready_resp,
   output logic                      dst_hready,
   input  logic                      dst_hresp,
   output logic [W_ADDR-1:0]         dst_haddr,
   output logic                      dst_hwrite,
   output logic [1:0]                dst_htrans,
   output logic [2:0]                dst_hsize,
   output logic [2:0]                dst_hburst,
   output logic [3:0]                dst_hprot,
   output logic                      dst_hmastlock,
   output logic [W_DATA-1:0]         dst_hwdata,
   input  logic [W_DATA-1:0]         dst_hrdata
);
   localparam int GW = $clog2(N_PORTS);
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] NSEQ = 2'b10;
   localparam logic [1:0] SEQ  = 2'b11;
   localparam logic [2:0] INCR = 3'b001;

   typedef struct packed {
      logic [W_ADDR-1:0] addr;
      logic              write;
      logic [1:0]        trans;
      logic [2:0]        size;
      logic [2:0]        burst;
      logic [3:0]        prot;
      logic              lock;
   } aph_t;

   aph_t               live [N_PORTS];
   aph_t               buf_q [N_PORTS];
   aph_t               buf_d [N_PORTS];
   aph_t               aph;
   logic [W_DATA-1:0]  wdata [N_PORTS];
   logic [N_PORTS-1:0] req, buf_valid_q, buf_valid_d;
   logic [GW-1:0]      grant_q, grant_d, dph_owner_q, dph_owner_d, pick;
   logic               hold_q, hold_d, dph_valid_q, dph_valid_d, found, act;
   logic [3:0]         cnt_q, cnt_d, len_m1;

   for (genvar i = 0; i < N_PORTS; i++) begin : g_port
      assign live[i] = {src_haddr[i*W_ADDR +: W_ADDR], src_hwrite[i], src_htrans[2*i +: 2],
                        src_hsize[3*i +: 3], src_hburst[3*i +: 3], src_hprot[4*i +: 4], src_hmastlock[i]};
      assign req[i] = src_hready[i] && src_htrans[2*i+1];
      assign wdata[i] = src_hwdata[i*W_DATA +: W_DATA];
      assign src_hready_resp[i] = (dph_valid_q && dph_owner_q == GW'(i)) ? dst_hready_resp : !buf_valid_q[i];
      assign src_hresp[i] = dph_valid_q && dph_owner_q == GW'(i) && dst_hresp;
      assign src_hrdata[i*W_DATA +: W_DATA] = dst_hrdata;
   end

   // A buffered entry always takes precedence over the live bus of the granted port.
   assign aph           = buf_valid_q[grant_q] ? buf_q[grant_q] : live[grant_q];
   assign act           = aph.trans != IDLE;
   assign dst_haddr     = aph.addr;
   assign dst_hwrite    = aph.write;
   assign dst_htrans    = aph.trans;
   assign dst_hsize     = aph.size;
   assign dst_hburst    = aph.burst;
   assign dst_hprot     = aph.prot;
   assign dst_hmastlock = aph.lock && act;
   assign dst_hready    = dst_hready_resp;
   assign dst_hwdata    = wdata[dph_owner_q];
   assign len_m1        = aph.burst[2:1] == 2'd1 ? 4'd3 : aph.burst[2:1] == 2'd2 ? 4'd7 :
                          aph.burst[2:1] == 2'd3 ? 4'd15 : 4'd0;

   always_comb begin
      buf_d = buf_q;
      buf_valid_d = buf_valid_q;
      if (dst_hready_resp && buf_valid_q[grant_q]) buf_valid_d[grant_q] = 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (req[i] && !(GW'(i) == grant_q && dst_hready_resp && !buf_valid_q[i])) begin
            buf_d[i] = live[i];
            buf_valid_d[i] = 1'b1;
         end
      end
   end

   always_comb begin
      pick = grant_q;
      found = 1'b0;
`ifdef AHB_CACHE_FILL_ARBITER_ROUND_ROBIN_EN
      for (int k = 1; k <= N_PORTS; k++) begin
         if (!found && buf_valid_d[GW'((int'(grant_q) + k) % N_PORTS)]) begin
            found = 1'b1;
            pick = GW'((int'(grant_q) + k) % N_PORTS);
         end
      end
`else
      for (int k = N_PORTS - 1; k >= 0; k--) begin
         if (buf_valid_d[GW'(k)]) begin
            found = 1'b1;
            pick = GW'(k);
         end
      end
`endif
   end

   // Ownership state only moves when the downstream accepts an address phase.
   always_comb begin
      cnt_d = cnt_q;
      hold_d = hold_q;
      dph_valid_d = dph_valid_q;
      dph_owner_d = dph_owner_q;
      grant_d = grant_q;
      if (dst_hready_resp) begin
         cnt_d = (dst_hresp || !act) ? 4'd0 : aph.trans == NSEQ ? len_m1 :
                 (aph.trans == SEQ && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
         hold_d = act && (aph.lock || cnt_d != 4'd0 || aph.burst == INCR);
         dph_valid_d = act;
         dph_owner_d = grant_q;
         grant_d = (!hold_d && found) ? pick : grant_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_valid_q <= '0;
         grant_q <= '0;
         hold_q <= 1'b0;
         cnt_q <= 4'd0;
         dph_valid_q <= 1'b0;
         dph_owner_q <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         grant_q <= grant_d;
         hold_q <= hold_d;
         cnt_q <= cnt_d;
         dph_valid_q <= dph_valid_d;
         dph_owner_q <= dph_owner_d;
      end
   end

   always_ff @(posedge clk) buf_q <= buf_d;
endmodule
